// File: rtl/pacman_pkg.sv
// Shared pacman map types: tile codes, default map size and the map writer's state codes.
package pacman_pkg;

    typedef enum logic [3:0] {
        EMPTY  = 4'd0,
        WALL   = 4'd1,
        PILL   = 4'd2,
        PACMAN = 4'd3,
        GHOST  = 4'd4
    } tile_t;

    localparam int unsigned MAP_W_DEF = 40;
    localparam int unsigned MAP_H_DEF = 30;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCheck  = 3'd1;
    localparam logic [2:0] StEval   = 3'd2;
    localparam logic [2:0] StErase  = 3'd3;
    localparam logic [2:0] StPlace  = 3'd4;
    localparam logic [2:0] StReject = 3'd5;
    localparam logic [2:0] StDone   = 3'd6;

endpackage

// File: rtl/tile_addr.sv
// Tile coordinate to linear RAM address: addr = y*MAP_W + x.
module tile_addr #(
    parameter int unsigned MAP_W  = 40,
    parameter int unsigned ADDR_W = 11
) (
    input  logic [5:0]        x,
    input  logic [4:0]        y,
    output logic [ADDR_W-1:0] addr
);

    assign addr = ADDR_W'(y) * ADDR_W'(MAP_W) + ADDR_W'(x);

endmodule

// File: rtl/pacman_map_writer.sv
// Commits a pacman move into the tile map RAM: read target, reject walls/out-of-range,
// erase the old cell, write pacman at the new cell, then pulse done.
module pacman_map_writer
    import pacman_pkg::*;
#(
    parameter int unsigned MAP_W  = MAP_W_DEF,
    parameter int unsigned MAP_H  = MAP_H_DEF,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [5:0]        curr_x,
    input  logic [4:0]        curr_y,
    input  logic [5:0]        next_x,
    input  logic [4:0]        next_y,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [3:0]        ram_wdata,
    input  logic [3:0]        ram_rdata,
    output logic              done,
    output logic              blocked,
    output logic              pill_eaten,
    output logic [CNT_W-1:0]  pills_eaten,
    output logic              busy
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    logic [2:0]        state;
    logic [5:0]        curr_x_q, next_x_q;
    logic [4:0]        curr_y_q, next_y_q;
    logic [1:0]        lat_cnt;
    logic              pill_q;
    logic              out_of_range;
    logic [ADDR_W-1:0] in_next_addr, curr_addr, next_addr;

    // The live next coords address lets CHECK present its read on the very first cycle.
    tile_addr #(.MAP_W(MAP_W), .ADDR_W(ADDR_W)) u_addr_in_next (
        .x    (next_x),
        .y    (next_y),
        .addr (in_next_addr)
    );

    tile_addr #(.MAP_W(MAP_W), .ADDR_W(ADDR_W)) u_addr_curr (
        .x    (curr_x_q),
        .y    (curr_y_q),
        .addr (curr_addr)
    );

    tile_addr #(.MAP_W(MAP_W), .ADDR_W(ADDR_W)) u_addr_next (
        .x    (next_x_q),
        .y    (next_y_q),
        .addr (next_addr)
    );

    // Also catches the 0-1 wrap to 6'h3F / 5'h1F coming from loc_ctrl.
    assign out_of_range = (32'(next_x) >= MAP_W) || (32'(next_y) >= MAP_H);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= StIdle;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= EMPTY;
            done        <= 1'b0;
            blocked     <= 1'b0;
            pill_eaten  <= 1'b0;
            pills_eaten <= '0;
            busy        <= 1'b0;
            curr_x_q    <= '0;
            curr_y_q    <= '0;
            next_x_q    <= '0;
            next_y_q    <= '0;
            lat_cnt     <= '0;
            pill_q      <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            done       <= 1'b0;
            blocked    <= 1'b0;
            pill_eaten <= 1'b0;
            case (state)
                StIdle: begin
                    if ({next_x, next_y} != {curr_x, curr_y}) begin
                        curr_x_q <= curr_x;
                        curr_y_q <= curr_y;
                        next_x_q <= next_x;
                        next_y_q <= next_y;
                        pill_q   <= 1'b0;
                        busy     <= 1'b1;
                        if (out_of_range) begin
                            state <= StReject;
                        end else begin
                            state    <= StCheck;
                            ram_addr <= in_next_addr;
                            lat_cnt  <= '0;
                        end
                    end
                end
                StCheck: begin
                    if (lat_cnt == LAT_LAST) state <= StEval;
                    else                     lat_cnt <= lat_cnt + 2'd1;
                end
                StEval: begin
                    if (ram_rdata == WALL) begin
                        state <= StReject;
                    end else begin
                        pill_q    <= (ram_rdata == PILL);
                        state     <= StErase;
                        ram_addr  <= curr_addr;
                        ram_wdata <= EMPTY;
                        ram_we    <= 1'b1;
                    end
                end
                StErase: begin
                    state     <= StPlace;
                    ram_addr  <= next_addr;
                    ram_wdata <= PACMAN;
                    ram_we    <= 1'b1;
                end
                StPlace: begin
                    state      <= StDone;
                    done       <= 1'b1;
                    pill_eaten <= pill_q;
                    if (pill_q && (pills_eaten != '1)) begin
                        pills_eaten <= pills_eaten + CNT_W'(1);
                    end
                end
                StReject: begin
                    state   <= StDone;
                    done    <= 1'b1;
                    blocked <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
